uart_irda_tx_ctrl: RTL

- Memory-mapped transmit controller for the MIPS system's serial port.
- The CPU writes bytes into a small FIFO. The controller schedules them one frame at a time onto a single serial line, as standard UART 8N1 or IrDA SIR.
- It generates the baud timing, sequences the start/data/stop bits, and reports status and an interrupt back to the CPU bus.

---
 rtl/uart_irda_tx_ctrl.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_irda_tx_ctrl.sv
// uart_irda_tx_ctrl
//   Memory-mapped transmit controller for the serial port. The CPU pushes
//   bytes into a small FIFO. The controller sends them one frame at a time,
//   as UART 8N1 or IrDA SIR. It generates the bit timing, drives the serial
//   line and raises a level interrupt when the transmitter has gone idle.
//
// Ports
//   clk    system clock
//   reset  asynchronous, active-high reset
//   cs     bus chip select
//   we     bus write enable (qualified by cs)
//   addr   register select: 0 DATA, 1 STATUS, 2 CTRL, 3 reserved
//   wdata  bus write data
//   rdata  bus read data, combinational from addr
//   tx     serial output, registered
//   irq    transmit-idle interrupt (irq_en & empty & ~busy)
//
// State | meaning
//   IDLE  | nothing in flight; tx holds the idle level of CTRL.irda_en
//   START | start bit (value 0)
//   DATA  | data bits 0..7, LSB first
//   STOP  | stop bit (value 1); chains straight into START if FIFO non-empty
module uart_irda_tx_ctrl #(
  parameter int CLK_DIV    = 27,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq
);

  localparam int          PW       = $clog2(FIFO_DEPTH);
  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [4:0]  DEPTH    = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [4:0]      count_q;
  logic            overflow_q;
  logic            irda_en_q, irq_en_q;
  logic            mode_q;
  logic [7:0]      shreg_q;
  logic [2:0]      bit_idx_q;
  logic [15:0]     div_q;
  logic [3:0]      subtick_q;
  logic            tx_q;

  logic            wr_data, wr_status, wr_ctrl;
  logic            empty, full, busy;
  logic            pop, push_ok, push_drop;
  logic            tick, bit_end;
  logic            bit_val, tx_d;
  logic [31:0]     status;
  logic            unused_wdata;

  assign unused_wdata = ^wdata[31:8];

  assign wr_data   = cs & we & (addr == 2'd0);
  assign wr_status = cs & we & (addr == 2'd1);
  assign wr_ctrl   = cs & we & (addr == 2'd2);

  assign empty = (count_q == 5'd0);
  assign full  = (count_q == DEPTH);
  assign busy  = (state_q != S_IDLE);

  // A pop in the same cycle frees a slot, so a push into a full FIFO is
  // still accepted then.
  assign push_ok   = wr_data & (~full | pop);
  assign push_drop = wr_data & full & ~pop;

  assign tick    = (div_q == DIV_LAST);
  assign bit_end = tick & (subtick_q == 4'd15);

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= wdata[7:0];
    end
  end

  // FIFO pointers, occupancy, sticky overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= 5'd0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push_ok && !pop) begin
        count_q <= count_q + 5'd1;
      end else if (pop && !push_ok) begin
        count_q <= count_q - 5'd1;
      end
      if (wr_status) begin
        overflow_q <= 1'b0;
      end else if (push_drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Control register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irda_en_q <= 1'b0;
      irq_en_q  <= 1'b0;
    end else if (wr_ctrl) begin
      irda_en_q <= wdata[0];
      irq_en_q  <= wdata[1];
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state, FIFO pop and next tx level
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    bit_val = 1'b1;
    tx_d    = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          state_d = S_START;
          pop     = 1'b1;
        end
      end
      S_START: begin
        bit_val = 1'b0;
        if (bit_end) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        bit_val = shreg_q[bit_idx_q];
        if (bit_end && bit_idx_q == 3'd7) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        bit_val = 1'b1;
        if (bit_end) begin
          if (!empty) begin
            state_d = S_START;
            pop     = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Idle level follows the live CTRL bit; inside a frame the latched mode
    // decides. IrDA sends a 3/16 high pulse for a zero and nothing for a one.
    if (state_q == S_IDLE) begin
      tx_d = ~irda_en_q;
    end else if (mode_q) begin
      tx_d = ~bit_val & (subtick_q < 4'd3);
    end else begin
      tx_d = bit_val;
    end
  end

  // Frame datapath: shift register, latched mode, bit timing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q   <= 8'd0;
      mode_q    <= 1'b0;
      bit_idx_q <= 3'd0;
      div_q     <= 16'd0;
      subtick_q <= 4'd0;
    end else if (pop) begin
      shreg_q   <= mem[rd_ptr_q];
      mode_q    <= irda_en_q;
      bit_idx_q <= 3'd0;
      div_q     <= 16'd0;
      subtick_q <= 4'd0;
    end else if (busy) begin
      if (tick) begin
        div_q     <= 16'd0;
        subtick_q <= subtick_q + 4'd1;
      end else begin
        div_q <= div_q + 16'd1;
      end
      if (bit_end && state_q == S_DATA) begin
        bit_idx_q <= bit_idx_q + 3'd1;
      end
    end
  end

  // Serial output; reset drives the line to mark immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_q <= 1'b1;
    end else begin
      tx_q <= tx_d;
    end
  end

  assign tx  = tx_q;
  assign irq = irq_en_q & empty & ~busy;

  assign status = {19'd0, count_q, 4'd0, overflow_q, busy, full, empty};

  always_comb begin
    rdata = 32'd0;
    case (addr)
      2'd1:    rdata = status;
      2'd2:    rdata = {30'd0, irq_en_q, irda_en_q};
      default: rdata = 32'd0;
    endcase
  end

endmodule
